// File: rtl/ternary_matmul_sequencer_if.sv
// Host-side streams of the ternary matmul sequencer: job command,
// operand-beat handshake and result-byte stream.
interface ternary_matmul_sequencer_if #(
  parameter int K_W = 8
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [K_W-1:0] cmd_len;
  logic           in_valid;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     out_data;
  logic           out_last;

  // Host / pin decoder side
  modport master (
    output cmd_valid, cmd_len, in_valid, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, out_last
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_len, in_valid, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ternary_matmul_sequencer.sv
// Control FSM for one ternary matrix-multiply job on the 8-accumulator
// systolic array: clear, stream K operand beats, snapshot, read out bytes.
// Optional build macro SEQ_RELU_EN clamps negative result bytes to zero.
//
// state | meaning
// IDLE  | waiting for a job command
// CLEAR | one-cycle accumulator clear
// ACCUM | consuming operand beats until beat_cnt == len_q
// COPY  | snapshot accumulators into the output queue
// READ  | streaming OUTPUTS result bytes to the host
module ternary_matmul_sequencer #(
  parameter int K_W     = 8,
  parameter int OUTPUTS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        abort,
  ternary_matmul_sequencer_if.slave   host,
  output logic                        arr_accumulate,
  output logic                        arr_reset_acc,
  output logic                        arr_copy_out,
  output logic [2:0]                  arr_out_index,
  input  logic [7:0]                  arr_out,
  output logic                        busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, COPY, READ} state_t;

  localparam logic [2:0] LAST_IDX = 3'(OUTPUTS - 1);

  state_t         state, state_nxt;
  logic [K_W-1:0] len_q;
  logic [K_W-1:0] beat_cnt;
  logic [2:0]     rd_idx;
  logic           kill;
  logic           cmd_fire;
  logic           beat_fire;
  logic           byte_fire;
  logic           last_byte;
  logic [7:0]     result;

  // Reset cancels a job exactly like abort does.
  assign kill      = reset | abort;
  assign last_byte = (rd_idx == LAST_IDX);

  // Next-state decode and Moore-style array/host strobes.
  always_comb begin
    state_nxt      = state;
    host.cmd_ready = 1'b0;
    host.in_ready  = 1'b0;
    host.out_valid = 1'b0;
    host.out_last  = 1'b0;
    arr_reset_acc  = 1'b0;
    arr_copy_out   = 1'b0;
    arr_out_index  = 3'd0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        host.cmd_ready = !kill;
        if (host.cmd_valid && !kill) state_nxt = CLEAR;
      end
      CLEAR: begin
        arr_reset_acc = 1'b1;
        state_nxt     = ACCUM;
      end
      ACCUM: begin
        host.in_ready = !kill;
        if (host.in_valid && !kill && (beat_cnt == len_q)) state_nxt = COPY;
      end
      COPY: begin
        arr_copy_out = !kill;
        state_nxt    = READ;
      end
      READ: begin
        host.out_valid = !kill;
        host.out_last  = !kill && last_byte;
        arr_out_index  = rd_idx;
        if (host.out_ready && !kill && last_byte) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill && (state != IDLE)) begin
      arr_reset_acc = 1'b1;
      state_nxt     = IDLE;
    end
  end

  assign cmd_fire       = host.cmd_valid & host.cmd_ready;
  assign arr_accumulate = host.in_valid & host.in_ready;
  assign beat_fire      = arr_accumulate;
  assign byte_fire      = host.out_valid & host.out_ready;

`ifdef SEQ_RELU_EN
  assign result = arr_out[7] ? 8'h00 : arr_out;
`else
  assign result = arr_out;
`endif

  // Result byte is forced to zero outside READ so the bus is quiet when idle.
  assign host.out_data = (state == READ) ? result : 8'h00;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Job length latch, beat counter and read-out index.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q    <= '0;
      beat_cnt <= '0;
      rd_idx   <= 3'd0;
    end else begin
      if (cmd_fire) begin
        len_q    <= host.cmd_len;
        beat_cnt <= '0;
      end else if (beat_fire) begin
        beat_cnt <= beat_cnt + K_W'(1);
      end
      if (state == COPY)  rd_idx <= 3'd0;
      else if (byte_fire) rd_idx <= rd_idx + 3'd1;
    end
  end

endmodule
